// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads the instruction ROM combinationally and
// hands registered words to decode over valid/ready; faults terminally on a bad address.
module instr_fetch_unit #(
    parameter int unsigned MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fault,
    output logic [63:0] fault_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic {RUN, FAULT} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } slot_t;

    // Highest word-aligned address whose 4 bytes fit in the ROM; comparing
    // against it avoids the a+3 overflow near 2^64.
    localparam logic [63:0] LAST_OK = 64'(MEM_SIZE) - 64'd4;

    function automatic logic bad_addr(input logic [63:0] a);
        return (a[1:0] != 2'b00) || (a > LAST_OK);
    endfunction

    state_t      state, state_n;
    logic [63:0] pc, pc_n;
    logic        vld, vld_n;
    slot_t       slot, slot_n;
    logic        flt, flt_n;
    logic [63:0] fpc, fpc_n;
    logic [31:0] cnt, cnt_n;
    logic        accept, slot_free;

    assign imem_addr   = pc;
    assign out_valid   = vld;
    assign out_instr   = slot.instr;
    assign out_pc      = slot.pc;
    assign fault       = flt;
    assign fault_pc    = fpc;
    assign fetch_count = cnt;

    assign accept    = vld && out_ready;
    assign slot_free = !vld || accept;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        vld_n   = vld;
        slot_n  = slot;
        flt_n   = flt;
        fpc_n   = fpc;
        cnt_n   = cnt;
        case (state)
            RUN: begin
                // An accept coinciding with a redirect still consumes the word.
                if (accept)
                    cnt_n = cnt + 32'd1;
                if (redirect) begin
                    vld_n = 1'b0;
                    if (bad_addr(redirect_pc)) begin
                        state_n = FAULT;
                        flt_n   = 1'b1;
                        fpc_n   = redirect_pc;
                    end else begin
                        pc_n = redirect_pc;
                    end
                end else if (slot_free) begin
                    if (bad_addr(pc)) begin
                        state_n = FAULT;
                        flt_n   = 1'b1;
                        fpc_n   = pc;
                        vld_n   = 1'b0;
                    end else begin
                        slot_n.instr = imem_instr;
                        slot_n.pc    = pc;
                        vld_n        = 1'b1;
                        pc_n         = pc + 64'd4;
                    end
                end
            end
            FAULT: begin
                vld_n = 1'b0;
            end
            default: begin
                state_n = FAULT;
                vld_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
            vld   <= 1'b0;
            slot  <= '0;
            flt   <= 1'b0;
            fpc   <= 64'd0;
            cnt   <= 32'd0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            vld   <= vld_n;
            slot  <= slot_n;
            flt   <= flt_n;
            fpc   <= fpc_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic, every
// cycle compared against a transaction-level fetch model.
module tb_instr_fetch_unit;

    localparam int unsigned MEM   = 1024;
    localparam int unsigned WORDS = MEM / 4;

    logic        clk;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;
    logic [63:0] fault_pc;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rom [WORDS];

    // model state
    logic [63:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [63:0] m_opc;
    logic        m_fault;
    logic [63:0] m_fpc;
    logic [31:0] m_cnt;

    instr_fetch_unit #(.MEM_SIZE(MEM), .RESET_PC(64'd0)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .fault(fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: out-of-range reads return a poison word so a bad capture is visible
    always_comb begin
        if (imem_addr < 64'(MEM)) imem_instr = rom[imem_addr[9:2]];
        else                      imem_instr = 32'hBAD0_BAD0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic bad(input logic [63:0] a);
        return (a % 4 != 0) || (a > 64'(MEM - 4));
    endfunction

    // One clock of the fetch contract, computed from the current model state.
    task automatic model_step(input logic r, input logic rd, input logic [63:0] rpc, input logic rdy);
        if (r) begin
            m_pc = 0; m_valid = 0; m_instr = 0; m_opc = 0;
            m_fault = 0; m_fpc = 0; m_cnt = 0;
        end else if (!m_fault) begin
            logic acc;
            acc = m_valid && rdy;
            if (acc) m_cnt = m_cnt + 1;
            if (rd) begin
                m_valid = 0;
                if (bad(rpc)) begin m_fault = 1; m_fpc = rpc; end
                else m_pc = rpc;
            end else if (!m_valid || acc) begin
                if (bad(m_pc)) begin
                    m_fault = 1; m_fpc = m_pc; m_valid = 0;
                end else begin
                    m_instr = rom[m_pc[9:2]];
                    m_opc   = m_pc;
                    m_valid = 1;
                    m_pc    = m_pc + 4;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".addr"},  imem_addr,   m_pc);
        chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, ".instr"}, 64'(out_instr), 64'(m_instr));
        chk({tag, ".opc"},   out_pc,      m_opc);
        chk({tag, ".fault"}, 64'(fault),  64'(m_fault));
        chk({tag, ".fpc"},   fault_pc,    m_fpc);
        chk({tag, ".cnt"},   64'(fetch_count), 64'(m_cnt));
    endtask

    task automatic step(input string tag, input logic r, input logic rd,
                        input logic [63:0] rpc, input logic rdy);
        reset = r; redirect = rd; redirect_pc = rpc; out_ready = rdy;
        model_step(r, rd, rpc, rdy);
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        for (int i = 0; i < int'(WORDS); i++) rom[i] = $urandom;
        reset = 1; redirect = 0; redirect_pc = 0; out_ready = 0;

        // T1: streaming from reset
        step("t1_rst", 1, 0, 0, 1);
        chk("t1_rst_valid", 64'(out_valid), 64'd0);
        chk("t1_rst_addr", imem_addr, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step("t1", 0, 0, 0, 1);
            chk("t1_pc", out_pc, 64'(i * 4));
            chk("t1_instr", 64'(out_instr), 64'(rom[i]));
        end

        // T2: stall holding out_pc=8
        for (int i = 0; i < 3; i++) begin
            step("t2", 0, 0, 0, 0);
            chk("t2_pc", out_pc, 64'd8);
            chk("t2_instr", 64'(out_instr), 64'(rom[2]));
            chk("t2_addr", imem_addr, 64'd12);
            chk("t2_cnt", 64'(fetch_count), 64'd2);
        end
        step("t2_rel", 0, 0, 0, 1);
        chk("t2_rel_pc", out_pc, 64'd12);

        // T3: redirect while out_pc=4 is accepted
        step("t3_rst", 1, 0, 0, 1);
        step("t3", 0, 0, 0, 1);
        step("t3", 0, 0, 0, 1);
        chk("t3_pc4", out_pc, 64'd4);
        step("t3_rd", 0, 1, 64'h40, 1);
        chk("t3_bubble", 64'(out_valid), 64'd0);
        chk("t3_cnt", 64'(fetch_count), 64'd2);
        step("t3_tgt", 0, 0, 0, 1);
        chk("t3_tgt_pc", out_pc, 64'h40);
        chk("t3_tgt_valid", 64'(out_valid), 64'd1);

        // T4: misaligned redirect faults; later redirect ignored
        step("t4_rd", 0, 1, 64'h42, 1);
        chk("t4_fault", 64'(fault), 64'd1);
        chk("t4_fpc", fault_pc, 64'h42);
        for (int i = 0; i < 3; i++) begin
            step("t4_hold", 0, (i == 0), 0, 1);
            chk("t4_hold_fault", 64'(fault), 64'd1);
            chk("t4_hold_valid", 64'(out_valid), 64'd0);
        end

        // T5: run off the end of the ROM
        step("t5_rst", 1, 0, 0, 1);
        for (int i = 0; i < int'(WORDS); i++) step("t5", 0, 0, 0, 1);
        chk("t5_last_pc", out_pc, 64'd1020);
        step("t5_end", 0, 0, 0, 1);
        chk("t5_fault", 64'(fault), 64'd1);
        chk("t5_fpc", fault_pc, 64'd1024);
        chk("t5_cnt", 64'(fetch_count), 64'd256);

        // T6: reset during stall in fault
        step("t6_stall", 0, 0, 0, 0);
        step("t6_rst", 1, 0, 0, 0);
        chk("t6_fault", 64'(fault), 64'd0);
        chk("t6_fpc", fault_pc, 64'd0);
        chk("t6_cnt", 64'(fetch_count), 64'd0);
        chk("t6_addr", imem_addr, 64'd0);
        chk("t6_opc", out_pc, 64'd0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic        r, rd, rdy;
            logic [63:0] rpc;
            r   = ($urandom_range(0, 59) == 0);
            rd  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       rpc = 64'($urandom_range(0, MEM - 1)) | 64'd1;
                1:       rpc = 64'(MEM) + 64'($urandom_range(0, 15) * 4);
                2:       rpc = 64'hFFFF_FFFF_FFFF_FFFC;
                default: rpc = 64'($urandom_range(0, WORDS - 1) * 4);
            endcase
            step("rnd", r, rd, rpc, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
